// File: rtl/dtree_class_vote_if.sv
// Sample-in / result-out bus of the class vote accumulator.
// slave modport is the vote block; master modport is the tree side plus result consumer.
// Both directions use valid/ready; err_invalid is a free-running status pulse.
interface dtree_class_vote_if #(
  parameter int CLASS_W = 4,
  parameter int CNT_W   = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [CLASS_W-1:0] in_class;
  logic               out_valid;
  logic               out_ready;
  logic [CLASS_W-1:0] out_class;
  logic [CNT_W-1:0]   out_votes;
  logic               out_tie;
  logic               err_invalid;

  modport slave (
    input  in_valid, in_class, out_ready,
    output in_ready, out_valid, out_class, out_votes, out_tie, err_invalid
  );

  modport master (
    output in_valid, in_class, out_ready,
    input  in_ready, out_valid, out_class, out_votes, out_tie, err_invalid
  );
endinterface

// File: rtl/dtree_class_vote.sv
// Windowed majority vote over per-sample decision-tree class codes.
// Result appears NUM_CLASSES+1 edges after the last sample of a window.
// in_ready drops for the whole scan and hold; result held until out_ready.
module dtree_class_vote #(
  parameter int CLASS_W     = 4,
  parameter int NUM_CLASSES = 10,
  parameter int WINDOW      = 8,
  parameter int CNT_W       = 4
) (
  input logic             clk,
  input logic             rst,
  dtree_class_vote_if.slave bus
);
  typedef enum logic [1:0] {ACCUM, SCAN, HOLD} state_t;

  localparam logic [CNT_W-1:0]   WIN_LAST = CNT_W'(WINDOW - 1);
  localparam logic [CLASS_W-1:0] IDX_LAST = CLASS_W'(NUM_CLASSES - 1);
  localparam logic [CLASS_W:0]   NUM_C    = (CLASS_W + 1)'(NUM_CLASSES);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   votes_q [NUM_CLASSES];
  logic [CNT_W-1:0]   votes_d [NUM_CLASSES];
  logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic [CLASS_W-1:0] scan_idx_q, scan_idx_d;
  logic [CLASS_W-1:0] best_q, best_d;
  logic [CNT_W-1:0]   best_votes_q, best_votes_d;
  logic               tie_q, tie_d;
  logic               out_valid_q, out_valid_d;
  logic [CLASS_W-1:0] out_class_q, out_class_d;
  logic [CNT_W-1:0]   out_votes_q, out_votes_d;
  logic               out_tie_q, out_tie_d;
  logic               err_q, err_d;
  logic               class_ok;
  logic [CNT_W-1:0]   scan_v;

  // No skid buffer: samples are only taken while accumulating.
  assign bus.in_ready    = (state_q == ACCUM) & ~rst;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_class   = out_class_q;
  assign bus.out_votes   = out_votes_q;
  assign bus.out_tie     = out_tie_q;
  assign bus.err_invalid = err_q;

  // Next-state: accumulate histogram, scan one class per cycle, hold result.
  always_comb begin
    state_d      = state_q;
    votes_d      = votes_q;
    sample_cnt_d = sample_cnt_q;
    scan_idx_d   = scan_idx_q;
    best_d       = best_q;
    best_votes_d = best_votes_q;
    tie_d        = tie_q;
    out_valid_d  = out_valid_q;
    out_class_d  = out_class_q;
    out_votes_d  = out_votes_q;
    out_tie_d    = out_tie_q;
    err_d        = 1'b0;
    class_ok     = ({1'b0, bus.in_class} < NUM_C);
    scan_v       = votes_q[scan_idx_q];

    case (state_q)
      ACCUM: begin
        if (bus.in_valid) begin
          sample_cnt_d = sample_cnt_q + 1'b1;
          if (class_ok) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
              if (bus.in_class == CLASS_W'(i)) votes_d[i] = votes_q[i] + 1'b1;
            end
          end else begin
            // Invalid codes still consume a window slot but cast no vote.
            err_d = 1'b1;
          end
          if (sample_cnt_q == WIN_LAST) begin
            state_d      = SCAN;
            scan_idx_d   = '0;
            best_d       = '0;
            best_votes_d = '0;
            tie_d        = 1'b0;
            sample_cnt_d = '0;
          end
        end
      end
      SCAN: begin
        // Strict '>' keeps the lowest index on equal counts.
        if (scan_v > best_votes_q) begin
          best_d       = scan_idx_q;
          best_votes_d = scan_v;
          tie_d        = 1'b0;
        end else if ((scan_v == best_votes_q) && (scan_v != '0)) begin
          tie_d = 1'b1;
        end
        if (scan_idx_q == IDX_LAST) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          out_class_d = best_d;
          out_votes_d = best_votes_d;
          out_tie_d   = tie_d;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          for (int i = 0; i < NUM_CLASSES; i++) votes_d[i] = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State registers with synchronous reset discarding any partial window or held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCUM;
      for (int i = 0; i < NUM_CLASSES; i++) votes_q[i] <= '0;
      sample_cnt_q <= '0;
      scan_idx_q   <= '0;
      best_q       <= '0;
      best_votes_q <= '0;
      tie_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_class_q  <= '0;
      out_votes_q  <= '0;
      out_tie_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      votes_q      <= votes_d;
      sample_cnt_q <= sample_cnt_d;
      scan_idx_q   <= scan_idx_d;
      best_q       <= best_d;
      best_votes_q <= best_votes_d;
      tie_q        <= tie_d;
      out_valid_q  <= out_valid_d;
      out_class_q  <= out_class_d;
      out_votes_q  <= out_votes_d;
      out_tie_q    <= out_tie_d;
      err_q        <= err_d;
    end
  end
endmodule

// File: tb/tb_dtree_class_vote.sv
// Bench for the windowed class vote block: directed scenarios plus randomized windows.
// Expected results come from a histogram model of each window's sample list.
// Consumer readiness is driven by the bench to exercise hold and backpressure.
module tb_dtree_class_vote;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dtree_class_vote_if #(.CLASS_W(4), .CNT_W(4)) itf ();
  dtree_class_vote #(.CLASS_W(4), .NUM_CLASSES(10), .WINDOW(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(itf)
  );

  int n_vec = 0;
  int n_err = 0;
  int acc_cnt = 0;
  int err_cnt = 0;
  int xfer_cnt = 0;

  always @(posedge clk) begin
    if (itf.in_valid === 1'b1 && itf.in_ready === 1'b1) acc_cnt <= acc_cnt + 1;
    if (itf.out_valid === 1'b1 && itf.out_ready === 1'b1) xfer_cnt <= xfer_cnt + 1;
  end
  always @(negedge clk) if (itf.err_invalid === 1'b1) err_cnt <= err_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Majority = most votes among legal codes, lowest code on ties; tie = other class shares a nonzero max.
  function automatic void model(input int s[$], output int cls, output int votes, output bit tie);
    int hist[10];
    int mx, nmx;
    foreach (hist[k]) hist[k] = 0;
    foreach (s[k]) if (s[k] < 10) hist[s[k]]++;
    mx = 0; cls = 0; nmx = 0;
    for (int c = 0; c < 10; c++) if (hist[c] > mx) begin mx = hist[c]; cls = c; end
    for (int c = 0; c < 10; c++) if (hist[c] == mx) nmx++;
    votes = mx;
    tie = (mx != 0) && (nmx > 1);
  endfunction

  task automatic send(input int c, input int gap);
    int guard;
    repeat (gap) begin @(negedge clk); itf.in_valid = 1'b0; end
    @(negedge clk);
    itf.in_valid = 1'b1;
    itf.in_class = 4'(c);
    guard = 0;
    while (itf.in_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_ready stuck at %b, required 1", itf.in_ready);
    end
    @(posedge clk);
  endtask

  task automatic send_list(input int s[$], input int gap);
    foreach (s[k]) send(s[k], gap);
  endtask

  // Waits for the result after a final accept; lat counts negedges until out_valid is seen.
  task automatic get_result(input int hold, output int lat, output logic [3:0] c,
                            output logic [3:0] v, output logic t, output logic rdy1);
    @(negedge clk);
    itf.in_valid = 1'b0;
    rdy1 = itf.in_ready;
    lat = 1;
    while (itf.out_valid !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
    c = itf.out_class; v = itf.out_votes; t = itf.out_tie;
    repeat (hold) @(negedge clk);
    itf.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    itf.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; itf.in_valid = 1'b1; itf.in_class = 4'd3; itf.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (itf.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", itf.in_ready); end
    n_vec++; if (itf.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", itf.out_valid); end
    n_vec++; if ({itf.out_class, itf.out_votes, itf.out_tie, itf.err_invalid} !== 10'd0) begin
      n_err++; $display("FAIL rst_outputs: got class %0d votes %0d tie %b err %b want all 0",
                        itf.out_class, itf.out_votes, itf.out_tie, itf.err_invalid); end
    n_vec++; if (acc_cnt !== 0) begin n_err++; $display("FAIL rst_no_accept: got %0d accepts want 0", acc_cnt); end
    rst = 1'b0; itf.in_valid = 1'b0;
    #1;
    n_vec++; if (itf.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", itf.in_ready); end
  endtask

  task automatic directed(input string name, input int s[$], input int gap);
    int ec, ev, lat, a0, e0, ninv;
    bit et;
    logic [3:0] c, v;
    logic t, rdy1;
    model(s, ec, ev, et);
    ninv = 0;
    foreach (s[k]) if (s[k] >= 10) ninv++;
    a0 = acc_cnt; e0 = err_cnt;
    send_list(s, gap);
    get_result(0, lat, c, v, t, rdy1);
    n_vec++; if (rdy1 !== 1'b0) begin n_err++; $display("FAIL %s_ready_drop: got %b want 0", name, rdy1); end
    n_vec++; if (lat != 11) begin n_err++; $display("FAIL %s_latency: got %0d want 11", name, lat); end
    n_vec++; if (c !== 4'(ec)) begin n_err++; $display("FAIL %s_class: got %0d want %0d", name, c, ec); end
    n_vec++; if (v !== 4'(ev)) begin n_err++; $display("FAIL %s_votes: got %0d want %0d", name, v, ev); end
    n_vec++; if (t !== et) begin n_err++; $display("FAIL %s_tie: got %b want %b", name, t, et); end
    n_vec++; if (acc_cnt - a0 != 8) begin n_err++; $display("FAIL %s_accepts: got %0d want 8", name, acc_cnt - a0); end
    n_vec++; if (err_cnt - e0 != ninv) begin n_err++; $display("FAIL %s_err_pulses: got %0d want %0d", name, err_cnt - e0, ninv); end
  endtask

  task automatic test_majority;  directed("majority", '{3,3,3,7,7,1,3,9}, 0); endtask
  task automatic test_tie;       directed("tie", '{2,2,5,5,0,1,4,6}, 0); endtask
  task automatic test_invalid;   directed("invalid", '{15,15,15,15,15,15,15,15}, 0); endtask
  task automatic test_bubbles;   directed("bubbles", '{4,4,4,4,4,4,4,4}, 1); endtask

  task automatic test_backpressure;
    int s[$];
    int ec, ev, guard, a0;
    bit et;
    logic [3:0] c, v;
    logic t;
    s = '{0,0,0,0,0,2,2,2};
    model(s, ec, ev, et);
    send_list(s, 0);
    guard = 0;
    @(negedge clk);
    while (itf.out_valid !== 1'b1 && guard < 60) begin @(negedge clk); guard++; end
    n_vec++; if (itf.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_result_timeout: out_valid %b want 1", itf.out_valid); end
    c = itf.out_class; v = itf.out_votes; t = itf.out_tie;
    n_vec++; if ({c, v, t} !== {4'(ec), 4'(ev), et}) begin
      n_err++; $display("FAIL bp_result: got %0d/%0d/%b want %0d/%0d/%b", c, v, t, ec, ev, et); end
    a0 = acc_cnt;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_vec++; if ({itf.out_valid, itf.out_class, itf.out_votes, itf.out_tie, itf.in_ready} !== {1'b1, c, v, t, 1'b0}) begin
        n_err++; $display("FAIL bp_hold_stable: cycle %0d got v%b %0d/%0d/%b rdy %b want v1 %0d/%0d/%b rdy 0",
                          k, itf.out_valid, itf.out_class, itf.out_votes, itf.out_tie, itf.in_ready, c, v, t); end
    end
    n_vec++; if (acc_cnt != a0) begin n_err++; $display("FAIL bp_no_accept: got %0d accepts want 0", acc_cnt - a0); end
    itf.in_valid = 1'b0; itf.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    itf.out_ready = 1'b0;
    n_vec++; if ({itf.in_ready, itf.out_valid} !== 2'b10) begin
      n_err++; $display("FAIL bp_release: got ready %b valid %b want ready 1 valid 0", itf.in_ready, itf.out_valid); end
    directed("bp_next", '{9,9,9,9,9,9,9,9}, 0);
  endtask

  task automatic test_reset_midwindow;
    int x0;
    send_list('{6,6,6,6,6}, 0);
    @(negedge clk);
    itf.in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    x0 = xfer_cnt;
    directed("rst_mid", '{1,1,1,1,1,1,1,1}, 0);
    n_vec++; if (xfer_cnt - x0 != 1) begin n_err++; $display("FAIL rst_mid_one_result: got %0d transfers want 1", xfer_cnt - x0); end
  endtask

  task automatic test_random;
    for (int w = 0; w < 8; w++) begin
      int s[$];
      int ec, ev, lat, e0, ninv, gap;
      bit et;
      logic [3:0] c, v;
      logic t, rdy1;
      s = {};
      ninv = 0;
      for (int k = 0; k < 8; k++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 15) s.push_back($urandom_range(10, 15));
        else if (w % 2 == 0) s.push_back($urandom_range(0, 3));
        else s.push_back($urandom_range(0, 9));
        if (s[k] >= 10) ninv++;
      end
      model(s, ec, ev, et);
      gap = $urandom_range(0, 2);
      e0 = err_cnt;
      foreach (s[k]) send(s[k], (k == 0) ? 0 : $urandom_range(0, gap));
      get_result($urandom_range(0, 3), lat, c, v, t, rdy1);
      n_vec++; if (lat != 11) begin n_err++; $display("FAIL rand%0d_latency: got %0d want 11", w, lat); end
      n_vec++; if ({c, v, t} !== {4'(ec), 4'(ev), et}) begin
        n_err++; $display("FAIL rand%0d_result: got %0d/%0d/%b want %0d/%0d/%b", w, c, v, t, ec, ev, et); end
      n_vec++; if (err_cnt - e0 != ninv) begin n_err++; $display("FAIL rand%0d_err_pulses: got %0d want %0d", w, err_cnt - e0, ninv); end
    end
  endtask

  initial begin
    test_reset;
    test_majority;
    test_tie;
    test_invalid;
    test_bubbles;
    test_backpressure;
    test_reset_midwindow;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
